fetch_unit: RTL and testbench

Instruction fetch front end placed between instruction memory and the decode/execute core. It holds the fetch PC and issues in-order word requests to a variable-latency instruction memory over a valid/ready request channel. Returned words are buffered with their PCs in a prefetch FIFO and presented to the core over a valid/ready channel. A redirect input from the branch unit flushes the FIFO, discards in-flight responses and restarts fetch at the new PC.

---
 rtl/fetch_unit.sv | 130 +++++++++++++
 tb/tb_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end.
// Holds the fetch PC, issues in-order word requests to a variable-latency
// instruction memory, buffers returned words with their PCs in a prefetch
// FIFO and presents them to the core. A redirect flushes the FIFO, marks all
// in-flight responses for discard and restarts fetch at the new PC.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   imem_req_*        request channel (valid/ready, 64-bit word address)
//   imem_resp_*       response channel (valid + 32-bit word, in request order)
//   redirect_*        branch unit restart request and target PC
//   out_*             instruction channel to the core (valid/ready, instr + pc)
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);

  logic [63:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;

  // Tag queue: PC of every in-flight request, including ones to be dropped.
  logic [63:0]   tag_mem [DEPTH];
  logic [AW-1:0] tag_wr;
  logic [AW-1:0] tag_rd;

  logic [31:0]   fifo_instr [DEPTH];
  logic [63:0]   fifo_pc    [DEPTH];
  logic [AW-1:0] fifo_wr;
  logic [AW-1:0] fifo_rd;

  logic [CW:0] in_use;
  logic        req_fire;
  logic        resp_ok;
  logic        push;
  logic        pop;

  // Dropped responses still occupy a credit until they return, so the
  // in-flight + buffered total never exceeds the FIFO depth.
  assign in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = !rst && !redirect_valid && (in_use < DEPTH_C);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign resp_ok = imem_resp_valid && (outstanding != '0);
  assign push    = resp_ok && !redirect_valid && (drop_cnt == '0);
  assign pop     = out_valid && out_ready && !redirect_valid;

  assign out_valid = (fifo_count != '0);
  assign out_instr = out_valid ? fifo_instr[fifo_rd] : 32'h0;
  assign out_pc    = out_valid ? fifo_pc[fifo_rd]    : 64'h0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
    end else begin
      if (req_fire) tag_wr <= tag_wr + 1'b1;
      if (resp_ok)  tag_rd <= tag_rd + 1'b1;

      case ({req_fire, resp_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      if (redirect_valid) begin
        fetch_pc   <= {redirect_pc[63:2], 2'b00};
        // No request issues in a redirect cycle, so everything still in
        // flight after this edge belongs to the old stream.
        drop_cnt   <= outstanding - CW'(resp_ok);
        fifo_count <= '0;
        fifo_wr    <= '0;
        fifo_rd    <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 64'd4;
        if (resp_ok && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        if (push) fifo_wr <= fifo_wr + 1'b1;
        if (pop)  fifo_rd <= fifo_rd + 1'b1;
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + 1'b1;
          2'b01:   fifo_count <= fifo_count - 1'b1;
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  // Storage arrays need no reset: validity is tracked by the pointers/counts.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[tag_wr] <= fetch_pc;
    if (push) begin
      fifo_instr[fifo_wr] <= imem_resp_data;
      fifo_pc[fifo_wr]    <= tag_mem[tag_rd];
    end
  end

  a_resp_protocol: assert property (@(posedge clk) disable iff (rst)
    !(imem_resp_valid && (outstanding == '0)));

  a_credit: assert property (@(posedge clk) disable iff (rst)
    in_use <= DEPTH_C);

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  logic [63:0] q_addr [$];
  int          q_due  [$];

  fetch_unit #(.RESET_PC(64'h0), .DEPTH(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: record the handshake decided by the current inputs, advance,
  // then drive this cycle's memory response (data = address of the word).
  task automatic tick();
    logic [63:0] a;
    if (imem_req_valid && imem_req_ready) begin
      q_addr.push_back(imem_req_addr);
      q_due.push_back(cyc + lat);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      a = q_addr.pop_front();
      void'(q_due.pop_front());
      imem_resp_valid = 1'b1;
      imem_resp_data  = a[31:0];
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    q_addr.delete();
    q_due.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst             = 1'b0;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'h0;
    out_ready       = 1'b1;
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_instr", 64'(out_instr), 64'd0);
    check("rst_out_pc", out_pc, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Zero-wait memory, one instruction per cycle.
    lat = 1;
    check("t1_req_valid", 64'(imem_req_valid), 64'd1);
    check("t1_addr0", imem_req_addr, 64'h0);
    tick();
    check("t1_addr1", imem_req_addr, 64'h4);
    check("t1_no_bypass", 64'(out_valid), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("t1_out_valid", 64'(out_valid), 64'd1);
      check("t1_out_pc", out_pc, 64'(4 * i));
      check("t1_out_instr", 64'(out_instr), 64'(4 * i));
      tick();
    end

    // Core stalled: credit limit of 4 requests.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_req_valid", 64'(imem_req_valid), 64'd1);
      check("t2_addr", imem_req_addr, 64'(4 * i));
      tick();
    end
    check("t2_credit_stop", 64'(imem_req_valid), 64'd0);
    tick();
    tick();
    check("t2_still_stop", 64'(imem_req_valid), 64'd0);
    check("t2_head_pc", out_pc, 64'h0);
    check("t2_head_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    check("t2_resume_valid", 64'(imem_req_valid), 64'd1);
    check("t2_resume_addr", imem_req_addr, 64'h10);
    check("t2_next_pc", out_pc, 64'h4);

    // Latency 3, two in flight, redirect discards both.
    do_reset();
    lat = 3;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    #1;
    check("t3_redir_gate", 64'(imem_req_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t3_new_addr", imem_req_addr, 64'h100);
    for (int i = 0; i < 4; i++) begin
      check("t3_dropped", 64'(out_valid), 64'd0);
      tick();
    end
    check("t3_out_valid", 64'(out_valid), 64'd1);
    check("t3_out_pc", out_pc, 64'h100);
    check("t3_out_instr", 64'(out_instr), 64'h100);

    // Misaligned redirect coincident with a response and a pop.
    do_reset();
    lat = 1;
    out_ready = 1'b1;
    tick();
    tick();
    check("t4_pre_valid", 64'(out_valid), 64'd1);
    check("t4_pre_resp", 64'(imem_resp_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h203;
    #1;
    check("t4_redir_gate", 64'(imem_req_valid), 64'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t4_flushed", 64'(out_valid), 64'd0);
    check("t4_aligned_addr", imem_req_addr, 64'h200);
    tick();
    check("t4_empty", 64'(out_valid), 64'd0);
    tick();
    check("t4_out_pc", out_pc, 64'h200);
    check("t4_out_valid", 64'(out_valid), 64'd1);

    // Memory not ready for 5 cycles, then PC wrap.
    do_reset();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", 64'(imem_req_valid), 64'd1);
      check("t5_hold_addr", imem_req_addr, 64'h0);
      tick();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("t5_top_addr", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    imem_req_ready = 1'b1;
    tick();
    check("t5_wrap_addr", imem_req_addr, 64'h0);
    tick();
    check("t5_top_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t5_top_instr", 64'(out_instr), 64'hFFFF_FFFC);

    // Asynchronous reset with 3 entries buffered.
    do_reset();
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    imem_req_ready = 1'b0;
    tick();
    imem_req_ready = 1'b1;
    #1;
    check("t6_buffered_valid", 64'(out_valid), 64'd1);
    check("t6_buffered_pc", out_pc, 64'h0);
    check("t6_req_before", 64'(imem_req_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("t6_async_out_valid", 64'(out_valid), 64'd0);
    check("t6_async_req_valid", 64'(imem_req_valid), 64'd0);
    check("t6_async_out_pc", out_pc, 64'h0);
    @(negedge clk);
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    q_addr.delete();
    q_due.delete();
    rst = 1'b0;
    #1;
    check("t6_restart_valid", 64'(imem_req_valid), 64'd1);
    check("t6_restart_addr", imem_req_addr, 64'h0);
    check("t6_restart_empty", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
